// File: rtl/param_restoring_divider_pkg.sv
// Shared definitions for the restoring divider.
// Holds the controller state encoding used by param_restoring_divider.
package param_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/param_restoring_divider_subtractor.sv
// param_subtractor: unsigned WIDTH-bit subtractor with borrow out.
// Ports:
//   a, b   : unsigned operands (WIDTH bits)
//   diff   : a - b, modulo 2**WIDTH
//   borrow : 1 when b > a
module param_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/param_restoring_divider.sv
// param_restoring_divider: multi-cycle unsigned restoring divider.
// One quotient bit per clock, dividend MSB first; SIZE iterations per
// division. A zero divisor short-circuits straight to DONE.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : request a division (accepted when busy=0)
//   dividend, divisor      : unsigned operands, latched on accept
//   quotient, remainder    : registered results, held until next result
//   busy                   : high while iterating
//   done                   : one-cycle result-valid pulse
//   div_by_zero            : qualifies done when divisor was 0
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | waiting for start
// RUN   | iterating, one quotient bit per clock
// DONE  | results valid for one cycle; start may be accepted here
module param_restoring_divider
  import param_restoring_divider_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = $clog2(SIZE) + 1;

  state_t state, state_nxt;

  logic [SIZE:0]   rem_r;
  logic [SIZE-1:0] dvd_sh;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [SIZE-1:0] dvs_r;
  logic [CW-1:0]   cnt;

  logic [SIZE:0]   r_shift;
  logic [SIZE:0]   diff;
  logic            borrow;
  logic [SIZE:0]   rem_nxt;
  logic [SIZE-1:0] dvd_nxt;
  logic            last_iter;
  logic            accept;

  assign r_shift = {rem_r[SIZE-1:0], dvd_sh[SIZE-1]};

  param_subtractor #(
    .WIDTH (SIZE + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, dvs_r}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_nxt   = borrow ? r_shift : diff;
  assign dvd_nxt   = {dvd_sh[SIZE-2:0], ~borrow};
  assign last_iter = (cnt == CW'(SIZE - 1));
  assign accept    = start && (state != RUN);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_r       <= '0;
      dvd_sh      <= '0;
      dvs_r       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd_sh <= dividend;
        dvs_r  <= divisor;
        rem_r  <= '0;
        cnt    <= '0;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        rem_r  <= rem_nxt;
        dvd_sh <= dvd_nxt;
        cnt    <= cnt + 1'b1;
        if (last_iter) begin
          quotient    <= dvd_nxt;
          remainder   <= rem_nxt[SIZE-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_restoring_divider.sv
// Testbench for param_restoring_divider: directed cases and random
// operands at SIZE=4, plus an exhaustive sweep at SIZE=2, all compared
// against plain integer division.
module tb_param_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start2;
  logic [3:0] a4, b4, q4, r4;
  logic [1:0] a2, b2, q2, r2;
  logic       busy4, done4, dz4, busy2, done2, dz2;

  int npass = 0;
  int ntot  = 0;
  logic [3:0] last_q, last_r;
  logic [1:0] last_q2, last_r2;

  always #5 clk = ~clk;

  param_restoring_divider #(.SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(b4),
    .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dz4)
  );

  param_restoring_divider #(.SIZE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(a2), .divisor(b2),
    .quotient(q2), .remainder(r2), .busy(busy2), .done(done2), .div_by_zero(dz2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a SIZE=4 division and wait for done. If ign > 0, a competing
  // start (2/1) is pulsed ign cycles into RUN and must be ignored.
  task automatic go4(input int a, input int b, input int ign);
    int   n, busy_cnt;
    bit   seen;
    logic [3:0] eq, er;
    logic edz;
    if (b == 0) begin eq = 4'hF; er = 4'(a); edz = 1'b1; end
    else begin eq = 4'(a / b); er = 4'(a % b); edz = 1'b0; end
    start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
    step();
    start4 = 1'b0;
    n = 0; busy_cnt = 0; seen = 0;
    while (!seen && n <= 20) begin
      if (done4) seen = 1;
      else begin
        if (busy4) busy_cnt++;
        chk("hold_result", {q4, r4}, {last_q, last_r});
        if (ign > 0 && n == ign) begin
          start4 = 1'b1; a4 = 4'd2; b4 = 4'd1;
        end
        step();
        start4 = 1'b0;
        n++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      // edges after the accept edge; a zero divisor lands in DONE on the accept edge itself
      chk("latency", n, (b == 0) ? 0 : 4);
      chk("busy_cycles", busy_cnt, (b == 0) ? 0 : 4);
      chk("quotient", q4, eq);
      chk("remainder", r4, er);
      chk("div_by_zero", dz4, edz);
      chk("busy_at_done", busy4, 0);
    end
    last_q = eq; last_r = er;
  endtask

  task automatic go2(input int a, input int b);
    int n;
    bit seen;
    logic [1:0] eq, er;
    if (b == 0) begin eq = 2'b11; er = 2'(a); end
    else begin eq = 2'(a / b); er = 2'(a % b); end
    start2 = 1'b1; a2 = 2'(a); b2 = 2'(b);
    step();
    start2 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n <= 10) begin
      if (done2) seen = 1;
      else begin step(); n++; end
    end
    if (!seen) chk("done2_timeout", 0, 1);
    else begin
      chk("latency2", n, (b == 0) ? 0 : 2);
      chk("quotient2", q2, eq);
      chk("remainder2", r2, er);
      chk("div_by_zero2", dz2, (b == 0) ? 1 : 0);
    end
    last_q2 = eq; last_r2 = er;
  endtask

  task automatic idle4();
    step();
    chk("done_one_cycle", done4, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
    a4 = '0; b4 = '0; a2 = '0; b2 = '0;
    last_q = '0; last_r = '0; last_q2 = '0; last_r2 = '0;
    step(); step();
    chk("rst_q", q4, 0);
    chk("rst_r", r4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_dz", dz4, 0);
    rst = 1'b0;
    step();

    go4(13, 3, 0); idle4();
    go4(5, 7, 0);
    go4(15, 1, 0); idle4();
    go4(9, 0, 0);  idle4();
    go4(13, 3, 1); idle4();

    // reset during iteration 2 of 13/3
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd3;
    step();
    start4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_q", q4, 0);
    chk("abort_r", r4, 0);
    chk("abort_dz", dz4, 0);
    last_q = '0; last_r = '0; last_q2 = '0; last_r2 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", done4, 0);
    end
    go4(6, 4, 0); idle4();

    // start accepted in the DONE cycle
    go4(13, 3, 0);
    go4(14, 5, 0);
    idle4();

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        go2(a, b);

    for (int k = 0; k < 150; k++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 15));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      go4(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      if ($urandom_range(0, 1) == 1) idle4();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
